// File: rtl/store_commit_buffer.sv
// Store commit buffer: holds LSU stores speculatively, moves them to a
// commit queue as the commit stage retires them, and drains the commit
// queue in order to the data cache one write at a time.
module store_commit_buffer #(
  parameter int unsigned DEPTH_SPEC   = 4,
  parameter int unsigned DEPTH_COMMIT = 8,
  parameter int unsigned PLEN         = 56,
  parameter int unsigned DATA_W       = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  st_valid_i,
  output logic                  st_ready_o,
  input  logic [PLEN-1:0]       st_paddr_i,
  input  logic [DATA_W-1:0]     st_data_i,
  input  logic [DATA_W/8-1:0]   st_be_i,
  input  logic                  commit_i,
  output logic                  commit_ready_o,
  output logic                  no_st_pending_o,
  input  logic [11:0]           page_offset_i,
  output logic                  page_offset_match_o,
  output logic                  req_valid_o,
  input  logic                  req_gnt_i,
  output logic [PLEN-1:0]       req_addr_o,
  output logic [DATA_W-1:0]     req_data_o,
  output logic [DATA_W/8-1:0]   req_be_o,
  input  logic                  ack_i
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned SP_W = (DEPTH_SPEC > 1) ? $clog2(DEPTH_SPEC) : 1;
  localparam int unsigned CP_W = (DEPTH_COMMIT > 1) ? $clog2(DEPTH_COMMIT) : 1;
  localparam logic [SP_W:0] SPEC_MAX   = DEPTH_SPEC[SP_W:0];
  localparam logic [CP_W:0] COMMIT_MAX = DEPTH_COMMIT[CP_W:0];

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_ACK
  } state_t;

  state_t state_q, state_d;

  // speculative queue storage and bookkeeping
  logic [PLEN-1:0]   spec_addr_q [DEPTH_SPEC];
  logic [DATA_W-1:0] spec_data_q [DEPTH_SPEC];
  logic [BE_W-1:0]   spec_be_q   [DEPTH_SPEC];
  logic [SP_W-1:0]   spec_head_q, spec_tail_q;
  logic [SP_W:0]     spec_count_q;

  // commit queue storage and bookkeeping
  logic [PLEN-1:0]   commit_addr_q [DEPTH_COMMIT];
  logic [DATA_W-1:0] commit_data_q [DEPTH_COMMIT];
  logic [BE_W-1:0]   commit_be_q   [DEPTH_COMMIT];
  logic [CP_W-1:0]   commit_head_q, commit_tail_q;
  logic [CP_W:0]     commit_count_q;

  // in-flight request, held from REQ until ack
  logic [PLEN-1:0]   req_addr_q;
  logic [DATA_W-1:0] req_data_q;
  logic [BE_W-1:0]   req_be_q;

  logic spec_full, spec_empty, commit_full, commit_empty;
  logic push, commit, pop, load_req;
  logic [SP_W-1:0] spec_rel;
  logic [CP_W-1:0] commit_rel;
  logic match;
  logic unused_offset_bits;

  assign spec_full    = (spec_count_q == SPEC_MAX);
  assign spec_empty   = (spec_count_q == '0);
  assign commit_full  = (commit_count_q == COMMIT_MAX);
  assign commit_empty = (commit_count_q == '0);

  assign push   = st_valid_i && !spec_full && !flush_i;
  assign commit = commit_i && !spec_empty && !commit_full;

  assign st_ready_o          = !spec_full;
  assign commit_ready_o      = !commit_full;
  assign no_st_pending_o     = commit_empty && (state_q == IDLE);
  assign req_addr_o          = req_addr_q;
  assign req_data_o          = req_data_q;
  assign req_be_o            = req_be_q;
  assign page_offset_match_o = match;
  assign unused_offset_bits  = ^page_offset_i[2:0];

  // speculative queue pointers and count; flush wins over push, a
  // same-cycle commit still copies its entry before the queue is cleared
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spec_head_q  <= '0;
      spec_tail_q  <= '0;
      spec_count_q <= '0;
    end else if (flush_i) begin
      spec_head_q  <= '0;
      spec_tail_q  <= '0;
      spec_count_q <= '0;
    end else begin
      if (push)   spec_tail_q <= spec_tail_q + 1'b1;
      if (commit) spec_head_q <= spec_head_q + 1'b1;
      case ({push, commit})
        2'b10:   spec_count_q <= spec_count_q + 1'b1;
        2'b01:   spec_count_q <= spec_count_q - 1'b1;
        default: spec_count_q <= spec_count_q;
      endcase
    end
  end

  // commit queue pointers and count; never touched by flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      commit_head_q  <= '0;
      commit_tail_q  <= '0;
      commit_count_q <= '0;
    end else begin
      if (commit) commit_tail_q <= commit_tail_q + 1'b1;
      if (pop)    commit_head_q <= commit_head_q + 1'b1;
      case ({commit, pop})
        2'b10:   commit_count_q <= commit_count_q + 1'b1;
        2'b01:   commit_count_q <= commit_count_q - 1'b1;
        default: commit_count_q <= commit_count_q;
      endcase
    end
  end

  // entry storage; validity is tracked purely by the counts above
  always_ff @(posedge clk_i) begin
    if (push) begin
      spec_addr_q[spec_tail_q] <= st_paddr_i;
      spec_data_q[spec_tail_q] <= st_data_i;
      spec_be_q[spec_tail_q]   <= st_be_i;
    end
    if (commit) begin
      commit_addr_q[commit_tail_q] <= spec_addr_q[spec_head_q];
      commit_data_q[commit_tail_q] <= spec_data_q[spec_head_q];
      commit_be_q[commit_tail_q]   <= spec_be_q[spec_head_q];
    end
  end

  // drain FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // drain FSM next state and request handshake
  always_comb begin
    state_d     = state_q;
    req_valid_o = 1'b0;
    load_req    = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!commit_empty) begin
          state_d  = REQ;
          load_req = 1'b1;
        end
      end
      REQ: begin
        req_valid_o = 1'b1;
        if (req_gnt_i) begin
          pop     = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // capture the commit head when a request starts; held through WAIT_ACK
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_addr_q <= '0;
      req_data_q <= '0;
      req_be_q   <= '0;
    end else if (load_req) begin
      req_addr_q <= commit_addr_q[commit_head_q];
      req_data_q <= commit_data_q[commit_head_q];
      req_be_q   <= commit_be_q[commit_head_q];
    end
  end

  // load hazard: any buffered or in-flight store on the same doubleword offset
  always_comb begin
    match      = 1'b0;
    spec_rel   = '0;
    commit_rel = '0;
    for (int unsigned i = 0; i < DEPTH_SPEC; i++) begin
      spec_rel = SP_W'(i) - spec_head_q;
      if (({1'b0, spec_rel} < spec_count_q) &&
          (spec_addr_q[i][11:3] == page_offset_i[11:3]))
        match = 1'b1;
    end
    for (int unsigned i = 0; i < DEPTH_COMMIT; i++) begin
      commit_rel = CP_W'(i) - commit_head_q;
      if (({1'b0, commit_rel} < commit_count_q) &&
          (commit_addr_q[i][11:3] == page_offset_i[11:3]))
        match = 1'b1;
    end
    if ((state_q != IDLE) && (req_addr_q[11:3] == page_offset_i[11:3]))
      match = 1'b1;
  end

`ifndef SYNTHESIS
  logic ack_orphan_q;

  // an ack for a write dropped by reset is legal until the next write starts
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                               ack_orphan_q <= 1'b1;
    else if (ack_i || (state_q == WAIT_ACK)) ack_orphan_q <= 1'b0;
  end

  a_commit_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    commit_i |-> (!spec_empty && !commit_full));

  a_ack_expected: assert property (@(posedge clk_i) disable iff (rst_i)
    ack_i |-> ((state_q == WAIT_ACK) || ack_orphan_q));
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Scoreboard bench for store_commit_buffer: directed stimulus, a monitor
// comparing every dcache write against the expected in-order write stream.
module tb_store_commit_buffer;

  localparam int unsigned PLEN   = 56;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic              st_valid_i;
  logic              st_ready_o;
  logic [PLEN-1:0]   st_paddr_i;
  logic [DATA_W-1:0] st_data_i;
  logic [BE_W-1:0]   st_be_i;
  logic              commit_i;
  logic              commit_ready_o;
  logic              no_st_pending_o;
  logic [11:0]       page_offset_i;
  logic              page_offset_match_o;
  logic              req_valid_o;
  logic              req_gnt_i;
  logic [PLEN-1:0]   req_addr_o;
  logic [DATA_W-1:0] req_data_o;
  logic [BE_W-1:0]   req_be_o;
  logic              ack_i;
  logic              ack_resp;
  logic              ack_force;
  logic              auto_ack = 1'b0;

  typedef struct {
    logic [PLEN-1:0]   a;
    logic [DATA_W-1:0] d;
    logic [BE_W-1:0]   be;
  } st_t;

  st_t spec_m[$];
  st_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  writes_seen = 0;

  assign ack_i = ack_resp | ack_force;

  always #5 clk_i = ~clk_i;

  store_commit_buffer #(
    .DEPTH_SPEC(4),
    .DEPTH_COMMIT(8),
    .PLEN(PLEN),
    .DATA_W(DATA_W)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .st_valid_i(st_valid_i),
    .st_ready_o(st_ready_o),
    .st_paddr_i(st_paddr_i),
    .st_data_i(st_data_i),
    .st_be_i(st_be_i),
    .commit_i(commit_i),
    .commit_ready_o(commit_ready_o),
    .no_st_pending_o(no_st_pending_o),
    .page_offset_i(page_offset_i),
    .page_offset_match_o(page_offset_match_o),
    .req_valid_o(req_valid_o),
    .req_gnt_i(req_gnt_i),
    .req_addr_o(req_addr_o),
    .req_data_o(req_data_o),
    .req_be_o(req_be_o),
    .ack_i(ack_i)
  );

  function automatic logic [DATA_W-1:0] data_of(input logic [PLEN-1:0] a);
    return {8'hA5, a};
  endfunction

  function automatic logic [BE_W-1:0] be_of(input logic [PLEN-1:0] a);
    case (a[4:3])
      2'd0:    return 8'hFF;
      2'd1:    return 8'h0F;
      2'd2:    return 8'hF0;
      default: return 8'h3C;
    endcase
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  // drive one cycle of LSU/commit/flush inputs and update the reference queues
  task automatic drive(input logic v, input logic [PLEN-1:0] a, input logic c, input logic f);
    st_t e;
    logic acc;
    acc        = v && !f && (spec_m.size() < 4);
    st_valid_i = v;
    st_paddr_i = a;
    st_data_i  = data_of(a);
    st_be_i    = be_of(a);
    commit_i   = c;
    flush_i    = f;
    if (c) begin
      e = spec_m.pop_front();
      exp_q.push_back(e);
    end
    if (f) spec_m.delete();
    if (acc) begin
      e.a  = a;
      e.d  = data_of(a);
      e.be = be_of(a);
      spec_m.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (!no_st_pending_o && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (!no_st_pending_o) begin
      failures++;
      $display("FAIL %s: still pending after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, "_st_ready"}, st_ready_o, 1'b1);
    chk1({tag, "_commit_ready"}, commit_ready_o, 1'b1);
    chk1({tag, "_no_pending"}, no_st_pending_o, 1'b1);
    chk1({tag, "_req_valid"}, req_valid_o, 1'b0);
    chk1({tag, "_match"}, page_offset_match_o, 1'b0);
    chkw({tag, "_req_addr"}, 64'(req_addr_o), 64'h0);
    chkw({tag, "_req_data"}, req_data_o, 64'h0);
    chkw({tag, "_req_be"}, 64'(req_be_o), 64'h0);
  endtask

  // monitor: every accepted dcache write must match the scoreboard head
  initial begin
    st_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_i && req_valid_o && req_gnt_i) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr 0x%0h required no write", req_addr_o);
        end else begin
          e = exp_q.pop_front();
          chkw("wr_addr", 64'(req_addr_o), 64'(e.a));
          chkw("wr_data", req_data_o, e.d);
          chkw("wr_be", 64'(req_be_o), 64'(e.be));
        end
      end
    end
  end

  // dcache responder: ack two cycles after each grant
  initial begin
    ack_resp = 1'b0;
    forever begin
      @(negedge clk_i);
      #2;
      if (auto_ack && !rst_i && req_valid_o && req_gnt_i) begin
        @(negedge clk_i);
        @(negedge clk_i);
        ack_resp = 1'b1;
        @(negedge clk_i);
        ack_resp = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wb;
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    st_valid_i    = 1'b0;
    st_paddr_i    = '0;
    st_data_i     = '0;
    st_be_i       = '0;
    commit_i      = 1'b0;
    page_offset_i = '0;
    req_gnt_i     = 1'b0;
    ack_force     = 1'b0;

    repeat (3) step();
    chk_reset("rst");
    rst_i = 1'b0;
    step();

    // fill the speculative queue, fifth push is refused
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 56'h1000 + 56'(8 * i), 1'b0, 1'b0);
      step();
      chk1("t1_no_pending", no_st_pending_o, 1'b1);
      chk1("t1_st_ready", st_ready_o, (i < 3));
    end
    drive(1'b1, 56'h1020, 1'b0, 1'b0);
    step();
    chk1("t1_full_ready", st_ready_o, 1'b0);
    chk1("t1_full_no_pending", no_st_pending_o, 1'b1);

    // single commit, gnt tied high, ack two cycles after gnt
    req_gnt_i = 1'b1;
    auto_ack  = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk1("t2_c1_req_valid", req_valid_o, 1'b0);
    chk1("t2_c1_no_pending", no_st_pending_o, 1'b0);
    chk1("t2_c1_st_ready", st_ready_o, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    chk1("t2_c2_req_valid", req_valid_o, 1'b1);
    chkw("t2_c2_addr", 64'(req_addr_o), 64'h1000);
    chkw("t2_c2_data", req_data_o, 64'hA500_0000_0000_1000);
    chkw("t2_c2_be", 64'(req_be_o), 64'hFF);
    chk1("t2_c2_no_pending", no_st_pending_o, 1'b0);
    step();
    chk1("t2_c3_req_valid", req_valid_o, 1'b0);
    chk1("t2_c3_no_pending", no_st_pending_o, 1'b0);
    step();
    chk1("t2_c4_no_pending", no_st_pending_o, 1'b0);
    step();
    chk1("t2_c5_no_pending", no_st_pending_o, 1'b1);

    // commit and flush in the same cycle: the committed entry survives
    drive(1'b1, 56'h1020, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk1("t3a_st_ready", st_ready_o, 1'b1);
    page_offset_i = 12'h010;
    #1 chk1("t3a_flushed_no_match", page_offset_match_o, 1'b0);
    page_offset_i = 12'h008;
    #1 chk1("t3a_committed_match", page_offset_match_o, 1'b1);
    page_offset_i = 12'h000;
    step();
    wait_idle("t3a_drain", 50);

    // push three, commit one, flush: exactly one write reaches the dcache
    wb = writes_seen;
    drive(1'b1, 56'h3000, 1'b0, 1'b0);
    step();
    drive(1'b1, 56'h3008, 1'b0, 1'b0);
    step();
    drive(1'b1, 56'h3010, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    drive(1'b1, 56'h3018, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk1("t3b_st_ready", st_ready_o, 1'b1);
    page_offset_i = 12'h008;
    #1 chk1("t3b_flushed_no_match", page_offset_match_o, 1'b0);
    page_offset_i = 12'h000;
    #1 chk1("t3b_inflight_match", page_offset_match_o, 1'b1);
    step();
    wait_idle("t3b_drain", 50);
    repeat (4) step();
    chkw("t3b_write_count", 64'(writes_seen - wb), 64'd1);

    // eight commits with gnt low fill the commit queue
    req_gnt_i = 1'b0;
    drive(1'b1, 56'h4000, 1'b0, 1'b0);
    step();
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 56'h4000 + 56'(8 * i), 1'b1, 1'b0);
      step();
      chk1("t4_commit_ready", commit_ready_o, 1'b1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk1("t4_full_commit_ready", commit_ready_o, 1'b0);
    chk1("t4_full_req_valid", req_valid_o, 1'b1);
    chkw("t4_full_addr", 64'(req_addr_o), 64'h4000);
    step();
    chk1("t4_hold_req_valid", req_valid_o, 1'b1);
    chkw("t4_hold_addr", 64'(req_addr_o), 64'h4000);
    chkw("t4_hold_data", req_data_o, 64'hA500_0000_0000_4000);
    chk1("t4_hold_commit_ready", commit_ready_o, 1'b0);
    req_gnt_i = 1'b1;
    step();
    chk1("t4_after_gnt_ready", commit_ready_o, 1'b1);
    wait_idle("t4_drain", 100);

    // page offset hazard through spec, commit, REQ and WAIT_ACK
    drive(1'b1, 56'h2A38, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    page_offset_i = 12'hA3C;
    #1 chk1("t5_spec_match", page_offset_match_o, 1'b1);
    page_offset_i = 12'hA40;
    #1 chk1("t5_next_dword_no_match", page_offset_match_o, 1'b0);
    page_offset_i = 12'hA3C;
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk1("t5_c1_match", page_offset_match_o, 1'b1);
    step();
    chk1("t5_c2_match", page_offset_match_o, 1'b1);
    chk1("t5_c2_req_valid", req_valid_o, 1'b1);
    step();
    chk1("t5_c3_match", page_offset_match_o, 1'b1);
    chk1("t5_c3_req_valid", req_valid_o, 1'b0);
    step();
    chk1("t5_c4_match", page_offset_match_o, 1'b1);
    step();
    chk1("t5_c5_match", page_offset_match_o, 1'b0);
    chk1("t5_c5_no_pending", no_st_pending_o, 1'b1);

    // reset while a write awaits ack with three more committed
    auto_ack      = 1'b0;
    page_offset_i = 12'h000;
    drive(1'b1, 56'h5000, 1'b0, 1'b0);
    step();
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 56'h5000 + 56'(8 * i), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk1("t6_wait_req_valid", req_valid_o, 1'b0);
    chk1("t6_wait_no_pending", no_st_pending_o, 1'b0);
    chk1("t6_wait_match", page_offset_match_o, 1'b1);
    step();
    chk1("t6_hold_req_valid", req_valid_o, 1'b0);
    chk1("t6_hold_match", page_offset_match_o, 1'b1);
    #3;
    rst_i = 1'b1;
    exp_q.delete();
    spec_m.delete();
    #1 chk_reset("t6_async");
    step();
    rst_i = 1'b0;
    step();
    ack_force = 1'b1;
    step();
    ack_force = 1'b0;
    repeat (5) begin
      step();
      chk1("t6_post_req_valid", req_valid_o, 1'b0);
      chk1("t6_post_no_pending", no_st_pending_o, 1'b1);
    end

    chkw("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
